// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
//   stages()       : number of ripple segments (pipeline stages) for a width
//   seg_width_ok() : true when the segment width tiles the operand width exactly
//   MODE_ADD/SUB   : encodings of the 'sub' input
package adder_pkg;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   function automatic int stages(input int width, input int seg_width);
      return width / seg_width;
   endfunction

   function automatic bit seg_width_ok(input int width, input int seg_width);
      return (seg_width > 0) && (width >= seg_width) && ((width % seg_width) == 0);
   endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational SEG_WIDTH-bit ripple-carry adder segment.
//   a, b  : segment operands
//   cin   : carry into bit 0
//   sum   : segment sum
//   cout  : carry out of the top bit
module adder_segment #(
   parameter int SEG_WIDTH = 4
) (
   input  logic [SEG_WIDTH-1:0] a,
   input  logic [SEG_WIDTH-1:0] b,
   input  logic                 cin,
   output logic [SEG_WIDTH-1:0] sum,
   output logic                 cout
);

   logic [SEG_WIDTH:0] c;

   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = cin;
      for (int i = 0; i < SEG_WIDTH; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      cout = c[SEG_WIDTH];
   end

endmodule

// File: rtl/pipelined_adder_nbit.sv
// Pipelined add/subtract unit with valid/ready handshake and global stall.
// Each stage adds one SEG_WIDTH segment; the carry is registered between
// stages. Operand bits not yet consumed travel forward (skew) and settled
// result bits travel forward (deskew) so the whole result leaves together.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : operand beat handshake
//   a, b, carry_in, sub   : operands; sub=1 computes a-b-carry_in
//   out_valid/out_ready   : result beat handshake
//   sum, carry_out        : result mod 2^WIDTH; carry_out=1 means no borrow in sub mode
//   overflow              : two's-complement overflow of the beat
module pipelined_adder_nbit
   import adder_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int SEG_WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int STAGES = stages(WIDTH, SEG_WIDTH);

   if (!seg_width_ok(WIDTH, SEG_WIDTH)) begin : g_bad_width
      $error("pipelined_adder_nbit: SEG_WIDTH must evenly divide WIDTH");
   end

   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;

   // Whole pipe moves as one; a held output freezes every stage.
   always_comb begin
      adv     = !out_valid || out_ready;
      b_eff   = (sub == MODE_SUB) ? ~b : b;
      cin_eff = (sub == MODE_ADD) ? carry_in : !carry_in;
   end

   assign in_ready = adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int LO = k * SEG_WIDTH;
      localparam int RW = LO + SEG_WIDTH;  // result bits settled after this stage

      logic [WIDTH-1:LO]     op_a;
      logic [WIDTH-1:LO]     op_b;
      logic                  c_in;
      logic                  v_in;
      logic [SEG_WIDTH-1:0]  seg_sum;
      logic                  seg_cout;
      logic [RW-1:0]         res_d;
      logic [RW-1:0]         res_q;
      logic                  carry_d;
      logic                  carry_q;
      logic                  valid_d;
      logic                  valid_q;

      if (k == 0) begin : g_first
         always_comb begin
            op_a = a;
            op_b = b_eff;
            c_in = cin_eff;
            v_in = in_valid;
         end
         always_comb begin
            res_d = seg_sum;
         end
      end else begin : g_next
         always_comb begin
            op_a = g_stg[k-1].g_fwd.a_q;
            op_b = g_stg[k-1].g_fwd.b_q;
            c_in = g_stg[k-1].carry_q;
            v_in = g_stg[k-1].valid_q;
         end
         always_comb begin
            res_d = {seg_sum, g_stg[k-1].res_q};
         end
      end

      adder_segment #(.SEG_WIDTH(SEG_WIDTH)) u_seg (
         .a    (op_a[LO +: SEG_WIDTH]),
         .b    (op_b[LO +: SEG_WIDTH]),
         .cin  (c_in),
         .sum  (seg_sum),
         .cout (seg_cout)
      );

      always_comb begin
         carry_d = seg_cout;
         valid_d = v_in;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            res_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
         end else if (adv) begin
            res_q   <= res_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
         end
      end

      if (k < STAGES - 1) begin : g_fwd
         // Operand bits above this segment, still waiting for their stage.
         logic [WIDTH-1:RW] a_d;
         logic [WIDTH-1:RW] a_q;
         logic [WIDTH-1:RW] b_d;
         logic [WIDTH-1:RW] b_q;

         always_comb begin
            a_d = op_a[WIDTH-1:RW];
            b_d = op_b[WIDTH-1:RW];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv) begin
               a_q <= a_d;
               b_q <= b_d;
            end
         end
      end else begin : g_last
         // Sign bits of both operands are only present in the top segment.
         logic ovf_d;
         logic ovf_q;

         always_comb begin
            ovf_d = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                    (seg_sum[SEG_WIDTH-1] != op_a[WIDTH-1]);
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q <= 1'b0;
            end else if (adv) begin
               ovf_q <= ovf_d;
            end
         end
      end
   end

   assign out_valid = g_stg[STAGES-1].valid_q;
   assign sum       = g_stg[STAGES-1].res_q;
   assign carry_out = g_stg[STAGES-1].carry_q;
   assign overflow  = g_stg[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Scoreboard bench: drivers push expected results when a beat is accepted,
// per-DUT monitors pop and compare whenever a result is delivered.
// dut16: WIDTH=16/SEG_WIDTH=4; dut4: WIDTH=4/SEG_WIDTH=1 for the exhaustive sweep.
module tb_pipelined_adder_nbit;
   import adder_pkg::*;

   typedef struct packed {
      logic [15:0] sum;
      logic        co;
      logic        ov;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   always #5 clk = ~clk;

   logic        iv16, ir16, vo16, or16, ci16, sub16, co16, ovf16;
   logic [15:0] a16, b16, s16;
   logic        iv4, ir4, vo4, or4, ci4, sub4, co4, ovf4;
   logic [3:0]  a4, b4, s4;

   pipelined_adder_nbit #(.WIDTH(16), .SEG_WIDTH(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
      .a(a16), .b(b16), .carry_in(ci16), .sub(sub16),
      .out_valid(vo16), .out_ready(or16), .sum(s16), .carry_out(co16), .overflow(ovf16));

   pipelined_adder_nbit #(.WIDTH(4), .SEG_WIDTH(1)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
      .a(a4), .b(b4), .carry_in(ci4), .sub(sub4),
      .out_valid(vo4), .out_ready(or4), .sum(s4), .carry_out(co4), .overflow(ovf4));

   exp_t q16[$];
   exp_t q4[$];
   int   n_total = 0;
   int   n_pass  = 0;
   int   cyc     = 0;
   int   acc_cyc = 0;
   bit   done    = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference: plain integer arithmetic on unsigned and signed views.
   function automatic exp_t model(input int w, input int a, input int b, input int ci, input int s);
      exp_t e;
      int   m    = 1 << w;
      int   full = s ? (a - b - ci) : (a + b + ci);
      int   sa   = (a >= m / 2) ? a - m : a;
      int   sb   = (b >= m / 2) ? b - m : b;
      int   sres = s ? (sa - sb - ci) : (sa + sb + ci);
      e.sum = 16'(full & (m - 1));
      e.co  = s ? (full >= 0) : (full >= m);
      e.ov  = (sres < -(m / 2)) || (sres > (m / 2) - 1);
      return e;
   endfunction

   task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic s, input exp_t e);
      int n = 0;
      a16 = a; b16 = b; ci16 = ci; sub16 = s; iv16 = 1'b1;
      forever begin
         @(negedge clk);
         if (ir16) begin
            q16.push_back(e);
            acc_cyc = cyc;
            @(posedge clk); #1;
            return;
         end
         n++;
         if (n > 100) begin
            check("send16_timeout", 32'd0, 32'd1);
            iv16 = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic s);
      int n = 0;
      a4 = a; b4 = b; ci4 = ci; sub4 = s; iv4 = 1'b1;
      forever begin
         @(negedge clk);
         if (ir4) begin
            q4.push_back(model(4, int'(a), int'(b), int'(ci), int'(s)));
            @(posedge clk); #1;
            return;
         end
         n++;
         if (n > 100) begin
            check("send4_timeout", 32'd0, 32'd1);
            iv4 = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic drain16();
      int n = 0;
      iv16 = 1'b0;
      while (q16.size() != 0 && n < 500) begin @(negedge clk); n++; end
      check("drain16_left", q16.size(), 0);
   endtask

   task automatic drain4();
      int n = 0;
      iv4 = 1'b0;
      while (q4.size() != 0 && n < 500) begin @(negedge clk); n++; end
      check("drain4_left", q4.size(), 0);
   endtask

   // Monitor for dut16: handshake rule, output hold under stall, result order.
   initial begin
      exp_t e;
      bit   stall = 1'b0;
      logic [17:0] held = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall = 1'b0;
         end else begin
            check("in_ready16", ir16, !(vo16 && !or16));
            if (stall) check("hold16", {vo16, s16, co16, ovf16}, {1'b1, held});
            if (vo16 && or16) begin
               if (q16.size() == 0) check("unexpected_beat16", {s16, co16, ovf16}, 32'hdead);
               else begin
                  e = q16.pop_front();
                  check("result16", {s16, co16, ovf16}, e);
               end
            end
            stall = vo16 && !or16;
            held  = {s16, co16, ovf16};
         end
      end
   end

   initial begin
      exp_t e;
      bit   stall = 1'b0;
      logic [5:0] held = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall = 1'b0;
         end else begin
            check("in_ready4", ir4, !(vo4 && !or4));
            if (stall) check("hold4", {vo4, s4, co4, ovf4}, {1'b1, held});
            if (vo4 && or4) begin
               if (q4.size() == 0) check("unexpected_beat4", {s4, co4, ovf4}, 32'hdead);
               else begin
                  e = q4.pop_front();
                  check("result4", {s4, co4, ovf4}, {e.sum[3:0], e.co, e.ov});
               end
            end
            stall = vo4 && !or4;
            held  = {s4, co4, ovf4};
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      rst_n = 1'b0;
      iv16 = 0; or16 = 1; a16 = 0; b16 = 0; ci16 = 0; sub16 = 0;
      iv4 = 0;  or4 = 1;  a4 = 0;  b4 = 0;  ci4 = 0;  sub4 = 0;
      repeat (2) @(negedge clk);
      check("reset16_outs", {vo16, s16, co16, ovf16}, 0);
      check("reset4_outs", {vo4, s4, co4, ovf4}, 0);
      @(posedge clk); #3 rst_n = 1'b1;
      @(negedge clk);
      check("in_ready16_after_reset", ir16, 1);
      @(posedge clk); #1;

      // Carry wrap; the accept edge counts as the first of STAGES=4 edges.
      send16(16'hFFFF, 16'h0001, 1'b0, MODE_ADD, '{16'h0000, 1'b1, 1'b0});
      iv16 = 1'b0;
      lat = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (vo16) begin lat = cyc - acc_cyc; break; end
      end
      check("latency16", lat, 4);
      @(posedge clk); #1;

      send16(16'h0003, 16'h0006, 1'b0, MODE_SUB, '{16'hFFFD, 1'b0, 1'b0});
      send16(16'h0003, 16'h0006, 1'b1, MODE_SUB, '{16'hFFFC, 1'b0, 1'b0});
      send16(16'h7FFF, 16'h0001, 1'b0, MODE_ADD, '{16'h8000, 1'b0, 1'b1});
      send16(16'h8000, 16'h0001, 1'b0, MODE_SUB, '{16'h7FFF, 1'b1, 1'b1});
      drain16();
      @(posedge clk); #1;

      // Backpressure: 8 back-to-back beats, out_ready low in cycles 5-7.
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               logic [15:0] ra, rb;
               logic rc, rs;
               ra = 16'($urandom); rb = 16'($urandom);
               rc = 1'($urandom); rs = 1'($urandom);
               send16(ra, rb, rc, rs, model(16, int'(ra), int'(rb), int'(rc), int'(rs)));
            end
            iv16 = 1'b0;
         end
         begin
            repeat (4) @(posedge clk);
            #1 or16 = 1'b0;
            repeat (3) @(posedge clk);
            #1 or16 = 1'b1;
         end
      join
      drain16();
      @(posedge clk); #1;

      // Random stream with random gaps and random backpressure.
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               logic [15:0] ra, rb;
               logic rc, rs;
               if ($urandom_range(0, 3) == 0) begin
                  iv16 = 1'b0;
                  @(posedge clk); #1;
               end
               ra = 16'($urandom); rb = 16'($urandom);
               rc = 1'($urandom); rs = 1'($urandom);
               send16(ra, rb, rc, rs, model(16, int'(ra), int'(rb), int'(rc), int'(rs)));
            end
            drain16();
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               or16 = ($urandom_range(0, 2) != 0);
            end
            or16 = 1'b1;
         end
      join
      @(posedge clk); #1;

      // Reset with three beats in flight.
      or16 = 1'b1;
      send16(16'h1111, 16'h2222, 1'b0, MODE_ADD, '{16'h3333, 1'b0, 1'b0});
      send16(16'h1234, 16'h0001, 1'b1, MODE_ADD, '{16'h1236, 1'b0, 1'b0});
      send16(16'h4000, 16'h4000, 1'b0, MODE_ADD, '{16'h8000, 1'b0, 1'b1});
      iv16 = 1'b0;
      rst_n = 1'b0;
      q16.delete();
      #1;
      check("midreset16_outs", {vo16, s16, co16, ovf16}, 0);
      @(posedge clk); #3 rst_n = 1'b1;
      @(negedge clk);
      check("in_ready16_after_midreset", ir16, 1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("no_stale16", vo16, 0);
      end
      @(posedge clk); #1;

      // Exhaustive 4-bit sweep with random out_ready.
      done = 1'b0;
      fork
         begin
            for (int s = 0; s < 2; s++)
               for (int c = 0; c < 2; c++)
                  for (int x = 0; x < 16; x++)
                     for (int y = 0; y < 16; y++)
                        send4(4'(x), 4'(y), 1'(c), 1'(s));
            drain4();
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               or4 = ($urandom_range(0, 3) != 0);
            end
            or4 = 1'b1;
         end
      join

      repeat (4) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pipelined_adder_nbit.md
# pipelined_adder_nbit

- Parametrised, pipelined add/subtract unit built from registered ripple segments.
- Generalises the fixed 4-bit combinational ripple adder in width, pipeline depth and mode (add/sub).
- Adds a valid/ready handshake with backpressure and a signed-overflow flag.
- Used wherever a wide adder must close timing at the core clock. It sits between operand producers and result consumers on a streaming datapath.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SEG_WIDTH (elaboration error otherwise)
- SEG_WIDTH, 4, bits added per pipeline stage; STAGES = WIDTH/SEG_WIDTH

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat present
- in_ready  out  1  unit accepts beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- carry_in  in  1  carry in (add) / borrow in (sub)
- sub  in  1  0: a+b+carry_in; 1: a-b-carry_in
- out_valid  out  1  result beat present
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result, modulo 2^WIDTH
- carry_out  out  1  carry out of MSB; in sub mode 1 = no borrow
- overflow  out  1  two's-complement overflow

## Operation
- Effective operands:
  - b_eff = b ^ {WIDTH{sub}}
  - cin_eff = carry_in ^ sub
  - Result = a + b_eff + cin_eff.
- Stage k (0..STAGES-1) adds segment k of a and b_eff plus the carry registered from stage k-1 (stage 0 uses cin_eff).
- Upper operand segments are carried forward in skew registers. Lower result segments are carried forward in deskew registers, so all WIDTH result bits leave together.
- overflow = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]). It is computed in the last stage and travels with its beat.
- Global stall:
  - adv = !out_valid || out_ready.
  - All pipeline and valid registers advance only when adv = 1.
  - in_ready = adv (combinational from out_ready and out_valid).
- Beat accepted when in_valid && in_ready. Result delivered when out_valid && out_ready.
- Bubbles: a stage valid bit is 0 when no beat was accepted. Bubbles advance and collapse when adv = 1.
- No reordering, duplication or loss. Results emerge in acceptance order.
- Reset (asserted at any time, including mid-stream):
  - All valid bits clear immediately. In-flight beats are discarded.
  - out_valid = 0, sum = 0, carry_out = 0, overflow = 0.
  - in_ready = 1 once reset is released.
- With out_valid = 1 and out_ready = 0, sum, carry_out and overflow hold stable.

## Timing
- Latency: STAGES cycles from accept edge to out_valid = 1 with no stall. Default: 4.
- Throughput: 1 beat/cycle while out_ready = 1.
- Capacity: STAGES beats in flight.
- Stall: if out_ready is low while out_valid is high, in_ready goes low the same cycle and the whole pipe freezes.
- in_valid && !in_ready: no accept; the producer holds the beat.
- Simultaneous accept and deliver in one cycle is legal and required.
- Critical path: one SEG_WIDTH ripple plus the carry register setup.

## Structure
- Package adder_pkg holds:
  - stage-count function stages(WIDTH, SEG_WIDTH)
  - MODE_ADD = 1'b0 and MODE_SUB = 1'b1 constants
  - the elaboration check that SEG_WIDTH divides WIDTH
- Sub-module adder_segment:
  - combinational SEG_WIDTH ripple of full adders with carry in/out
  - instantiated STAGES times by generate
  - registers live in the top level

## Test plan
WIDTH=16, SEG_WIDTH=4 unless noted.
- Carry wrap: a=0xFFFF, b=0x0001, carry_in=0, sub=0 -> 4 cycles later sum=0x0000, carry_out=1, overflow=0.
- Subtract: a=0x0003, b=0x0006, carry_in=0, sub=1 -> sum=0xFFFD, carry_out=0, overflow=0. Same operands with carry_in=1 -> sum=0xFFFC.
- Overflow:
  - 0x7FFF+0x0001 (sub=0) -> sum=0x8000, overflow=1.
  - 0x8000-0x0001 (sub=1) -> sum=0x7FFF, overflow=1, carry_out=1.
- Backpressure:
  - Stimulus: 8 back-to-back beats; out_ready low for cycles 5-7.
  - Check in_ready low exactly when out_valid && !out_ready.
  - Check all 8 results correct, in order, none duplicated.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight -> out_valid=0 and sum=0 immediately; after release no stale beat appears.
- Exhaustive: WIDTH=4, SEG_WIDTH=1 (4 stages), all a, b, carry_in and sub combinations streamed with random out_ready -> every result matches the behavioural model a ± b ± carry_in.
